// File: rtl/fa_dma_pkg.sv
// Shared definitions for the DMA port arbiter: FSM states, port indices, port counts.
package fa_dma_pkg;

    localparam int NUM_PORTS = 6;
    localparam int NUM_WR    = 2;   // ports 0..NUM_WR-1 write, the rest read

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;
    localparam logic [2:0] P5 = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WXFER = 2'd2,
        RXFER = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational 6-way round-robin pick: the search starts at (last+1) mod 6.
module rr_pick
    import fa_dma_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [2:0]           i_last,
    output logic [NUM_PORTS-1:0] o_onehot,
    output logic [2:0]           o_idx
);

    logic w_found;

    // Walk the ports in rotating order and take the first requester.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            int p;
            p = (int'(i_last) + k) % NUM_PORTS;
            if (!w_found && i_req[p]) begin
                w_found     = 1'b1;
                o_onehot[p] = 1'b1;
                o_idx       = 3'(p);
            end
        end
    end

endmodule

// File: rtl/dma_port_arbiter.sv
// Arbitrates six DMA ports (p0/p1 writers, p2..p5 readers) onto one memory
// command/data channel, one BURST_LEN-word burst per grant.
// Optional macro WRITE_PRIO_EN: pending writers beat readers in arbitration.
module dma_port_arbiter
    import fa_dma_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
    input  logic [NUM_WR*DATA_W-1:0]    ib_data,
    input  logic [NUM_WR-1:0]           ib_valid,
    output logic [NUM_WR-1:0]           ib_re,
    output logic [DATA_W-1:0]           ob_data,
    output logic [3:0]                  ob_we,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic                        mem_cmd_we,
    output logic [ADDR_W-1:0]           mem_cmd_addr,
    output logic                        mem_wr_valid,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_wr_ready,
    input  logic                        mem_rd_valid,
    input  logic [DATA_W-1:0]           mem_rd_data,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        err
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_e                           r_state, w_next;
    logic [NUM_PORTS-1:0]             r_grant;
    logic [2:0]                       r_sel, r_last;
    logic [CNT_W-1:0]                 r_cnt;
    logic [ADDR_W-1:0]                r_cmd_addr;
    logic                             r_cmd_we, r_err;
    logic [DATA_W-1:0]                r_ob_data;
    logic [3:0]                       r_ob_we;

    logic [NUM_PORTS-1:0]             w_req_eff, w_win_oh;
    logic [2:0]                       w_win_idx;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] w_addr;
    logic                             w_beat, w_last_beat;

    assign w_addr = port_addr;

`ifdef WRITE_PRIO_EN
    // Writers present: hide the readers so results drain first.
    assign w_req_eff = (|req[NUM_WR-1:0]) ? {{(NUM_PORTS-NUM_WR){1'b0}}, req[NUM_WR-1:0]} : req;
`else
    assign w_req_eff = req;
`endif

    rr_pick u_pick (
        .i_req    (w_req_eff),
        .i_last   (r_last),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx)
    );

    assign w_last_beat = (r_cnt == CNT_W'(BURST_LEN - 1));

    // Write-beat handshake is combinational through to the input buffer pop.
    always_comb begin
        mem_cmd_valid = (r_state == CMD);
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        ib_re         = '0;
        w_beat        = 1'b0;
        if (r_state == WXFER) begin
            mem_wr_valid    = ib_valid[r_sel[0]];
            mem_wr_data     = r_sel[0] ? ib_data[2*DATA_W-1:DATA_W] : ib_data[DATA_W-1:0];
            ib_re[r_sel[0]] = mem_wr_valid & mem_wr_ready;
            w_beat          = mem_wr_valid & mem_wr_ready;
        end else if (r_state == RXFER) begin
            w_beat = mem_rd_valid;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: arbitrate, issue command, move beats until the burst is full.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (|w_req_eff)   w_next = CMD;
            CMD:   if (mem_cmd_ready) w_next = r_cmd_we ? WXFER : RXFER;
            WXFER,
            RXFER: if (w_beat && w_last_beat) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant/command latch, beat counter, read return path and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_sel      <= '0;
            r_last     <= P5;
            r_cnt      <= '0;
            r_cmd_addr <= '0;
            r_cmd_we   <= 1'b0;
            r_err      <= 1'b0;
            r_ob_data  <= '0;
            r_ob_we    <= '0;
        end else begin
            r_ob_we <= '0;
            if (mem_rd_valid) begin
                if (r_state == RXFER) begin
                    r_ob_data <= mem_rd_data;
                    r_ob_we   <= 4'b0001 << (r_sel - P2);
                end else begin
                    r_err <= 1'b1;   // nobody asked for this beat; drop it
                end
            end
            case (r_state)
                IDLE: if (|w_req_eff) begin
                    r_grant    <= w_win_oh;
                    r_sel      <= w_win_idx;
                    r_cmd_addr <= w_addr[w_win_idx];
                    r_cmd_we   <= (w_win_idx < 3'(NUM_WR));
                end
                CMD: if (mem_cmd_ready) r_cnt <= '0;
                WXFER,
                RXFER: if (w_beat) begin
                    if (w_last_beat) begin
                        r_last  <= r_sel;
                        r_grant <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant        = r_grant;
    assign mem_cmd_addr = r_cmd_addr;
    assign mem_cmd_we   = r_cmd_we;
    assign err          = r_err;
    assign ob_data      = r_ob_data;
    assign ob_we        = r_ob_we;

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Randomized bench for dma_port_arbiter with a transaction-level reference
// model (expected winner, burst ownership, beat counts, read return data).
module tb_dma_port_arbiter;

    localparam int BL = 16;
    localparam int AW = 30;
    localparam int DW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [5:0]     req;
    logic [6*AW-1:0] port_addr;
    logic [2*DW-1:0] ib_data;
    logic [1:0]     ib_valid;
    logic [1:0]     ib_re;
    logic [DW-1:0]  ob_data;
    logic [3:0]     ob_we;
    logic           mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [AW-1:0]  mem_cmd_addr;
    logic           mem_wr_valid, mem_wr_ready, mem_rd_valid;
    logic [DW-1:0]  mem_wr_data, mem_rd_data;
    logic [5:0]     grant;
    logic           err;

    dma_port_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .port_addr(port_addr),
        .ib_data(ib_data), .ib_valid(ib_valid), .ib_re(ib_re),
        .ob_data(ob_data), .ob_we(ob_we),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // reference model: 0 idle, 1 command outstanding, 2 transferring
    int         m_phase, m_owner, m_last, m_beats, n_bursts;
    logic       m_we, m_err;
    logic [3:0] exp_obwe;
    logic [DW-1:0] exp_obdata;
    int         q_win[$];

    // stimulus knobs
    int cmd_pct = 100, wr_pct = 100, rd_pct = 100, ib_mode = 0, cyc = 0;
    bit seq_data = 0, stray = 0;
    int n_obwe, n_ibre;

    function automatic int exp_pick(logic [5:0] rq, int last);
        logic [5:0] cand;
        cand = rq;
`ifdef WRITE_PRIO_EN
        if (rq[1:0] != 2'b00) cand = rq & 6'b000011;
`endif
        for (int k = 1; k <= 6; k++) begin
            int p;
            p = (last + k) % 6;
            if (cand[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 5; m_beats = 0;
        m_we = 0; m_err = 0; exp_obwe = 0; exp_obdata = 0;
        q_win.delete();
    endtask

    // One clock: drive at posedge+1, check combinational outputs, advance the
    // model, then check registered outputs after the edge.
    task automatic tick();
        bit rd_ok, beat, wv;
        logic [1:0] exp_re;
        cyc++;
        mem_cmd_ready = ($urandom_range(0, 99) < cmd_pct);
        mem_wr_ready  = ($urandom_range(0, 99) < wr_pct);
        ib_valid      = (ib_mode == 1) ? {2{(cyc % 3) == 0}} : 2'($urandom);
        ib_data       = $urandom;
        rd_ok         = (m_phase == 2 && !m_we);
        mem_rd_valid  = (rd_ok && $urandom_range(0, 99) < rd_pct) || stray;
        mem_rd_data   = seq_data ? 16'h3a07 + 16'(m_beats) : 16'($urandom);
        #1;
        if (m_phase == 2 && m_we) begin
            wv     = ib_valid[m_owner];
            exp_re = 2'(wv & mem_wr_ready) << m_owner;
            n_vec++;
            if (mem_wr_valid !== wv) begin n_err++; $display("FAIL wr_valid cyc=%0d got %b want %b", cyc, mem_wr_valid, wv); end
            n_vec++;
            if (ib_re !== exp_re) begin n_err++; $display("FAIL ib_re cyc=%0d got %b want %b", cyc, ib_re, exp_re); end
            if (wv) begin
                n_vec++;
                if (mem_wr_data !== ib_data[m_owner*DW +: DW]) begin
                    n_err++; $display("FAIL wr_data cyc=%0d got %h want %h", cyc, mem_wr_data, ib_data[m_owner*DW +: DW]);
                end
            end
        end else begin
            n_vec++;
            if (mem_wr_valid !== 1'b0 || ib_re !== 2'b00) begin
                n_err++; $display("FAIL wr_idle cyc=%0d got valid=%b re=%b want 0/00", cyc, mem_wr_valid, ib_re);
            end
        end
        n_ibre += int'(ib_re[0]) + int'(ib_re[1]);

        exp_obwe = 0;
        case (m_phase)
            0: if (req != 0) begin
                m_owner = exp_pick(req, m_last); m_we = (m_owner < 2); m_phase = 1;
                q_win.push_back(m_owner);
            end
            1: if (mem_cmd_ready) begin m_phase = 2; m_beats = 0; end
            default: begin
                beat = m_we ? (ib_valid[m_owner] && mem_wr_ready) : mem_rd_valid;
                if (!m_we && mem_rd_valid) begin
                    exp_obwe = 4'b0001 << (m_owner - 2); exp_obdata = mem_rd_data;
                end
                if (beat) begin
                    m_beats++;
                    if (m_beats == BL) begin m_phase = 0; m_last = m_owner; n_bursts++; end
                end
            end
        endcase
        if (mem_rd_valid && !rd_ok) m_err = 1;

        @(posedge clk); #1;
        n_vec++;
        if (grant !== ((m_phase == 0) ? 6'b0 : 6'b1 << m_owner)) begin
            n_err++; $display("FAIL grant cyc=%0d got %b owner=%0d phase=%0d", cyc, grant, m_owner, m_phase);
        end
        n_vec++;
        if (mem_cmd_valid !== (m_phase == 1)) begin
            n_err++; $display("FAIL cmd_valid cyc=%0d got %b want %b", cyc, mem_cmd_valid, m_phase == 1);
        end
        if (m_phase != 0) begin
            n_vec++;
            if (mem_cmd_addr !== port_addr[m_owner*AW +: AW] || mem_cmd_we !== m_we) begin
                n_err++; $display("FAIL cmd_addr cyc=%0d got %h/%b want %h/%b", cyc, mem_cmd_addr, mem_cmd_we, port_addr[m_owner*AW +: AW], m_we);
            end
        end
        n_vec++;
        if (err !== m_err) begin n_err++; $display("FAIL err cyc=%0d got %b want %b", cyc, err, m_err); end
        n_vec++;
        if (ob_we !== exp_obwe) begin n_err++; $display("FAIL ob_we cyc=%0d got %b want %b", cyc, ob_we, exp_obwe); end
        if (exp_obwe != 0) begin
            n_vec++;
            if (ob_data !== exp_obdata) begin n_err++; $display("FAIL ob_data cyc=%0d got %h want %h", cyc, ob_data, exp_obdata); end
        end
        n_obwe += (ob_we != 0) ? 1 : 0;
    endtask

    task automatic run_bursts(int nb, int maxc, output bit done);
        int target, c;
        target = n_bursts + nb; c = 0;
        while (n_bursts < target && c < maxc) begin tick(); c++; end
        done = (n_bursts >= target);
    endtask

    task automatic wait_started(int maxc, output bit done);
        int c;
        c = 0;
        while (m_phase == 0 && c < maxc) begin tick(); c++; end
        done = (m_phase != 0);
    endtask

    task automatic do_reset();
        rst = 1; req = 0; stray = 0; mem_rd_valid = 0; mem_cmd_ready = 0;
        mem_wr_ready = 0; ib_valid = 0; ib_mode = 0; seq_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = 0; mem_rd_valid = 0; ib_valid = 0;
        mem_cmd_ready = 0; mem_wr_ready = 0; mem_rd_data = 0; ib_data = 0;
        #2;
        n_vec++;
        if (grant !== 0 || mem_cmd_valid !== 0 || mem_cmd_we !== 0 || mem_cmd_addr !== 0 ||
            ob_we !== 0 || ob_data !== 0 || err !== 0 || mem_wr_valid !== 0 || ib_re !== 0) begin
            n_err++; $display("FAIL reset_outputs got grant=%b cv=%b we=%b addr=%h obwe=%b obd=%h err=%b want all 0",
                grant, mem_cmd_valid, mem_cmd_we, mem_cmd_addr, ob_we, ob_data, err);
        end
        do_reset();
    endtask

    task automatic test_single_reader();
        bit ok;
        do_reset();
        port_addr[2*AW +: AW] = 30'h100;
        req = 6'b000100; seq_data = 1; cmd_pct = 100; rd_pct = 60; n_obwe = 0;
        wait_started(10, ok);
        req = 0;
        run_bursts(1, 400, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL reader_timeout got incomplete burst want done"); end
        n_vec++;
        if (n_obwe != BL) begin n_err++; $display("FAIL reader_obwe_count got %0d want %0d", n_obwe, BL); end
        n_vec++;
        if (q_win.size() != 1 || q_win[0] != 2) begin n_err++; $display("FAIL reader_winner got size %0d want p2", q_win.size()); end
        seq_data = 0; rd_pct = 100;
    endtask

    task automatic test_single_writer();
        bit ok;
        do_reset();
        req = 6'b000001; ib_mode = 1; wr_pct = 100; n_ibre = 0;
        wait_started(10, ok);
        req = 0;
        run_bursts(1, 400, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL writer_timeout got incomplete burst want done"); end
        n_vec++;
        if (n_ibre != BL) begin n_err++; $display("FAIL writer_ibre_count got %0d want %0d", n_ibre, BL); end
        ib_mode = 0;
    endtask

    task automatic test_all_six();
        bit ok;
        int exp_ord[$];
        do_reset();
        cmd_pct = 70; wr_pct = 70; rd_pct = 70;
        req = 6'b111111;
`ifdef WRITE_PRIO_EN
        exp_ord = '{0, 1, 0, 1, 2, 3};
        run_bursts(4, 3000, ok);
        req = 6'b111100;
        if (ok) run_bursts(2, 1500, ok);
`else
        exp_ord = '{0, 1, 2, 3, 4, 5, 0};
        run_bursts(7, 4000, ok);
`endif
        req = 0;
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL order_timeout got %0d grants", q_win.size()); end
        for (int i = 0; i < exp_ord.size(); i++) begin
            n_vec++;
            if (i >= q_win.size() || q_win[i] != exp_ord[i])
                begin n_err++; $display("FAIL order[%0d] got %0d want %0d", i, (i < q_win.size()) ? q_win[i] : -1, exp_ord[i]); end
        end
        cmd_pct = 100; wr_pct = 100; rd_pct = 100;
    endtask

    task automatic test_req_drop_and_stray();
        bit ok;
        int c;
        do_reset();
        req = 6'b001000; rd_pct = 80; n_obwe = 0; c = 0;
        while (!(m_phase == 2 && m_beats >= 5) && c < 200) begin tick(); c++; end
        req = 0;
        run_bursts(1, 400, ok);
        n_vec++;
        if (!ok || n_obwe != BL) begin n_err++; $display("FAIL req_drop_beats got %0d want %0d", n_obwe, BL); end
        stray = 1; tick(); stray = 0; tick();
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL stray_err got %b want 1", err); end
        n_vec++;
        if (n_obwe != BL) begin n_err++; $display("FAIL stray_obwe got %0d want %0d", n_obwe, BL); end
        rd_pct = 100;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int c;
        // err is still set from the stray beat, so the reset must clear it
        req = 6'b000100; rd_pct = 100; c = 0;
        while (!(m_phase == 2 && m_beats == 7) && c < 200) begin tick(); c++; end
        req = 0;
        rst = 1; mem_rd_valid = 0;
        @(posedge clk); #1;
        n_vec++;
        if (grant !== 0 || mem_cmd_valid !== 0 || err !== 0 || ob_we !== 0) begin
            n_err++; $display("FAIL mid_reset got grant=%b cv=%b err=%b obwe=%b want 0", grant, mem_cmd_valid, err, ob_we);
        end
        model_reset();
        rst = 0;
        req = 6'b111111;
        run_bursts(1, 400, ok);
        req = 0;
        n_vec++;
        if (!ok || q_win.size() == 0 || q_win[0] != 0) begin
            n_err++; $display("FAIL post_reset_first got %0d want 0", (q_win.size() > 0) ? q_win[0] : -1);
        end
    endtask

    task automatic test_random();
        int b0;
        do_reset();
        b0 = n_bursts;
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == 0 || $urandom_range(0, 7) == 0) req = 6'($urandom);
            cmd_pct = $urandom_range(30, 100);
            wr_pct  = $urandom_range(30, 100);
            rd_pct  = $urandom_range(30, 100);
            tick();
        end
        req = 0;
        n_vec++;
        if (n_bursts - b0 < 5) begin n_err++; $display("FAIL random_progress got %0d bursts want >=5", n_bursts - b0); end
    endtask

    initial begin
        n_bursts = 0;
        port_addr = '0;
        for (int i = 0; i < 6; i++) port_addr[i*AW +: AW] = 30'($urandom);
        test_reset();
        test_single_reader();
        test_single_writer();
        test_all_six();
        test_req_drop_and_stray();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
